// File: rtl/spi_slave_regfile.sv
// SPI slave register file clocked by the SPI serial clock. Each 16-bit frame
// is a command byte followed by a data byte. Reads stream back on mosi_s.
module spi_slave_regfile #(
  parameter int            DW        = 8,
  parameter logic [DW-1:0] RESET_VAL = 8'h00,
  parameter logic [DW-1:0] ID_VAL    = 8'hA5
) (
  input  logic          sclk_s,
  input  logic          rst,
  input  logic          ss_s,
  input  logic          miso_s,
  output logic          mosi_s,
  output logic [DW-1:0] reg0,
  output logic [DW-1:0] reg1,
  output logic [DW-1:0] reg2,
  output logic          frame_done,
  output logic          frame_err,
  output logic [7:0]    frame_cnt
);

  localparam int            CW   = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] bit_cnt;
  logic [DW-2:0] sh;
  logic [DW-1:0] shift_in;
  logic [DW-1:0] cmd;
  logic [DW-1:0] rd_sr;
  logic [DW-1:0] rd_val;
  logic          cmd_bad;
  logic          cmd_wr_ok;

  assign shift_in = {sh, miso_s};

  // Reserved bits or an attempted write to the read-only ID address make the frame illegal.
  assign cmd_bad   = (cmd[DW-2:2] != '0) || (cmd[DW-1] && cmd[1:0] == 2'd3);
  assign cmd_wr_ok = cmd[DW-1] && !cmd_bad;

  always_comb begin
    rd_val = '0;
    if (shift_in[DW-2:2] == '0) begin
      case (shift_in[1:0])
        2'd0:    rd_val = reg0;
        2'd1:    rd_val = reg1;
        2'd2:    rd_val = reg2;
        default: rd_val = ID_VAL;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!ss_s) state_next = CMD;
      CMD:  if (ss_s) state_next = IDLE; else if (bit_cnt == LAST) state_next = DATA;
      DATA: if (ss_s) state_next = IDLE; else if (bit_cnt == LAST) state_next = DONE;
      DONE: if (ss_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sclk_s) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge sclk_s) begin
    if (!rst) begin
      bit_cnt    <= '0;
      sh         <= '0;
      cmd        <= '0;
      rd_sr      <= '0;
      mosi_s     <= 1'b0;
      reg0       <= RESET_VAL;
      reg1       <= RESET_VAL;
      reg2       <= RESET_VAL;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (ss_s) begin
        // Deselect aborts any partial frame without touching the registers.
        bit_cnt <= '0;
        mosi_s  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sh      <= shift_in[DW-2:0];
            bit_cnt <= CW'(1);
          end
          CMD: begin
            sh <= shift_in[DW-2:0];
            if (bit_cnt == LAST) begin
              cmd     <= shift_in;
              bit_cnt <= '0;
              mosi_s  <= rd_val[DW-1];
              rd_sr   <= {rd_val[DW-2:0], 1'b0};
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          DATA: begin
            sh     <= shift_in[DW-2:0];
            mosi_s <= rd_sr[DW-1];
            rd_sr  <= {rd_sr[DW-2:0], 1'b0};
            if (bit_cnt == LAST) begin
              bit_cnt    <= '0;
              frame_done <= 1'b1;
              frame_err  <= cmd_bad;
              frame_cnt  <= frame_cnt + 8'd1;
              if (cmd_wr_ok) begin
                case (cmd[1:0])
                  2'd0:    reg0 <= shift_in;
                  2'd1:    reg1 <= shift_in;
                  2'd2:    reg2 <= shift_in;
                  default: ;
                endcase
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          DONE: mosi_s <= 1'b0;
          default: mosi_s <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: frames are shifted in bit by bit and
// registers, pulses, counter and serial read data are compared to fixed values.
module tb_spi_slave_regfile;

  logic       sclk_s = 1'b0;
  logic       rst    = 1'b0;
  logic       ss_s   = 1'b1;
  logic       miso_s = 1'b0;
  logic       mosi_s;
  logic [7:0] reg0, reg1, reg2;
  logic       frame_done, frame_err;
  logic [7:0] frame_cnt;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt, err_cnt, both_cnt;
  logic [7:0] rd_byte;

  spi_slave_regfile dut (
    .sclk_s     (sclk_s),
    .rst        (rst),
    .ss_s       (ss_s),
    .miso_s     (miso_s),
    .mosi_s     (mosi_s),
    .reg0       (reg0),
    .reg1       (reg1),
    .reg2       (reg2),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 sclk_s = ~sclk_s;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic countPulses();
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (frame_done && frame_err) both_cnt++;
  endtask

  // Shifts nbits of frame MSB first with ss_s low, pulling rst low at edge rst_at
  // (0 = never), then deselects for one edge; read data is what mosi_s shows before each data edge.
  task automatic applyStimulus(input logic [15:0] frame, input int nbits, input int rst_at);
    done_cnt = 0;
    err_cnt  = 0;
    both_cnt = 0;
    rd_byte  = '0;
    for (int k = 1; k <= nbits; k++) begin
      ss_s   = 1'b0;
      miso_s = frame[16-k];
      rst    = (k == rst_at) ? 1'b0 : 1'b1;
      @(posedge sclk_s);
      #1;
      countPulses();
      if (k >= 8 && k <= 15) rd_byte[15-k] = mosi_s;
    end
    ss_s   = 1'b1;
    rst    = 1'b1;
    miso_s = 1'b0;
    @(posedge sclk_s);
    #1;
    countPulses();
  endtask

  initial begin
    rst  = 1'b0;
    ss_s = 1'b1;
    repeat (2) @(posedge sclk_s);
    #1;
    checkOutput("rst_reg0", reg0, 8'h00);
    checkOutput("rst_reg1", reg1, 8'h00);
    checkOutput("rst_reg2", reg2, 8'h00);
    checkOutput("rst_mosi", mosi_s, 1'b0);
    checkOutput("rst_cnt", frame_cnt, 8'd0);
    checkOutput("rst_done", frame_done, 1'b0);
    checkOutput("rst_err", frame_err, 1'b0);
    rst = 1'b1;

    applyStimulus(16'h813C, 16, 0);
    checkOutput("wr1_reg1", reg1, 8'h3C);
    checkOutput("wr1_reg0", reg0, 8'h00);
    checkOutput("wr1_reg2", reg2, 8'h00);
    checkOutput("wr1_done", done_cnt, 1);
    checkOutput("wr1_err", err_cnt, 0);
    checkOutput("wr1_cnt", frame_cnt, 8'd1);

    applyStimulus(16'h015A, 16, 0);
    checkOutput("rd1_data", rd_byte, 8'h3C);
    checkOutput("rd1_reg1", reg1, 8'h3C);
    checkOutput("rd1_done", done_cnt, 1);
    checkOutput("rd1_cnt", frame_cnt, 8'd2);

    applyStimulus(16'h0300, 16, 0);
    checkOutput("rd3_data", rd_byte, 8'hA5);
    checkOutput("rd3_err", err_cnt, 0);
    checkOutput("rd3_cnt", frame_cnt, 8'd3);

    applyStimulus(16'h83FF, 16, 0);
    checkOutput("wr3_both", both_cnt, 1);
    checkOutput("wr3_err", err_cnt, 1);
    checkOutput("wr3_regs", {reg0, reg1}, 16'h003C);
    checkOutput("wr3_reg2", reg2, 8'h00);
    checkOutput("wr3_cnt", frame_cnt, 8'd4);

    applyStimulus(16'h82C3, 16, 0);
    checkOutput("wr2_reg2", reg2, 8'hC3);
    applyStimulus(16'h0211, 16, 0);
    checkOutput("rd2_data", rd_byte, 8'hC3);
    checkOutput("rd2_cnt", frame_cnt, 8'd6);

    applyStimulus(16'h8055, 11, 0);
    checkOutput("abort_done", done_cnt, 0);
    checkOutput("abort_reg0", reg0, 8'h00);
    checkOutput("abort_cnt", frame_cnt, 8'd6);
    applyStimulus(16'h0000, 16, 0);
    checkOutput("post_abort_done", done_cnt, 1);
    checkOutput("post_abort_data", rd_byte, 8'h00);
    checkOutput("post_abort_cnt", frame_cnt, 8'd7);

    applyStimulus(16'h8055, 15, 0);
    checkOutput("late_ss_done", done_cnt, 0);
    checkOutput("late_ss_reg0", reg0, 8'h00);
    checkOutput("late_ss_cnt", frame_cnt, 8'd7);

    applyStimulus(16'h4477, 16, 0);
    checkOutput("rsv_err", both_cnt, 1);
    checkOutput("rsv_data", rd_byte, 8'h00);
    checkOutput("rsv_reg0", reg0, 8'h00);
    applyStimulus(16'hC5EE, 16, 0);
    checkOutput("rsv_wr_err", err_cnt, 1);
    checkOutput("rsv_wr_reg1", reg1, 8'h3C);
    checkOutput("rsv_cnt", frame_cnt, 8'd9);

    applyStimulus(16'h8055, 16, 12);
    checkOutput("midrst_reg0", reg0, 8'h00);
    checkOutput("midrst_reg1", reg1, 8'h00);
    checkOutput("midrst_reg2", reg2, 8'h00);
    checkOutput("midrst_done", done_cnt, 0);
    checkOutput("midrst_cnt", frame_cnt, 8'd0);

    for (int i = 0; i < 255; i++) applyStimulus(16'h0300, 16, 0);
    checkOutput("cnt_255", frame_cnt, 8'd255);
    applyStimulus(16'h0300, 16, 0);
    checkOutput("cnt_wrap", frame_cnt, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
